neuron_mac: RTL and testbench
=============================

// Module: neuron_mac
// PURPOSE
//  Sequential multiply-accumulate front end of the neuron. Takes N_INPUTS signed
//  (x, w) pairs over a valid/ready stream and forms a saturated signed dot product.
//  Its 17-bit result is the in1 operand of the downstream bias adder.
//  One result per frame. A frame is opened by start and closed by an output handshake.
// PARAMETERS
//  N_INPUTS  2   pairs per frame (>=1)
//  DATA_W    8   width of x_in and w_in (signed)
//  ACC_W     17  accumulator/result width (signed, saturating)
// PORTS
//  clk        in   1        rising-edge clock, single domain
//  rst_n      in   1        synchronous active-low reset
//  start      in   1        open a frame; sampled only in IDLE
//  x_valid    in   1        x_in/w_in pair valid
//  x_ready    out  1        pair accepted when x_valid && x_ready
//  x_in       in   DATA_W   signed activation
//  w_in       in   DATA_W   signed weight
//  acc_out    out  ACC_W    signed dot-product result, registered
//  acc_valid  out  1        acc_out holds a finished result
//  out_ready  in   1        consumer takes result when acc_valid && out_ready
//  busy       out  1        state != IDLE
//  overflow   out  1        sticky per frame: saturation occurred
// BEHAVIOUR
//  Reset (rst_n=0 at posedge; synchronous)
//   - Effect: state=IDLE, acc_out=0, count=0, acc_valid=0, x_ready=0, busy=0, overflow=0.
//   - Applies from any state; a frame in progress is discarded and no result is emitted.
//  FSM: IDLE -> ACCUM -> DONE -> IDLE
//   - IDLE: x_ready=0. On start=1: acc_out<=0, count<=0, overflow<=0, go to ACCUM.
//   - ACCUM: x_ready=1. Each accepted pair does acc_out<=sat(acc_out + x_in*w_in) and count++.
//     The accept that makes count==N_INPUTS goes to DONE.
//     With x_valid=0, state and acc_out hold.
//   - DONE: acc_valid=1, x_ready=0. acc_out and overflow are stable.
//     On out_ready=1, go to IDLE; acc_valid drops the next cycle.
//  Timing
//   - acc_valid rises the cycle after the final accepted pair.
//   - Minimum frame length is N_INPUTS+2 cycles (start, N accepts, handoff).
//   - acc_valid registered; x_ready, busy decoded from state.
//  Arithmetic
//   - Product is 2*DATA_W bits, signed. It is sign-extended to ACC_W+1 bits before the add.
//   - Sum range is [-2^(ACC_W-1), 2^(ACC_W-1)-1], i.e. [-65536, 65535] at the defaults.
//   - Out-of-range sums clamp to the nearest bound and set overflow.
//   - Later accepts continue from the clamped value.
//  Boundaries
//   - start outside IDLE is ignored. That includes start in the same cycle as the DONE handoff;
//     it must be re-presented in IDLE.
//   - x_valid outside ACCUM is ignored; no pair is consumed.
//   - After handoff, acc_out and overflow hold their last values until the next start.
//   - N_INPUTS=1: a single accept goes ACCUM->DONE.
//   - Counter width is $clog2(N_INPUTS+1) and never wraps within a frame.
// TESTING
//  1. Reset, then idle 5 cycles -> all outputs 0, x_ready=0, busy=0.
//  2. N=2: start; pairs (3,4), (-5,6); out_ready=1 -> acc_out=-18 (0x1FFEE), acc_valid
//     one cycle after the 2nd accept, overflow=0, back to IDLE.
//  3. N=2: pairs (-128,-128) x2 -> acc_out=32768, overflow=0.
//     N=5: same pair x5 -> acc_out=65535, overflow=1.
//     N=5: pair (-128,127) x5 -> acc_out=-65536, overflow=1.
//  4. N=2: x_valid toggled 1,0,0,1 and out_ready held 0 for 4 cycles -> only 2 accepts,
//     acc_valid held 4 cycles with acc_out stable; start pulses while busy are ignored.
//  5. N=2: rst_n=0 for 1 cycle after the 1st accept -> state IDLE, acc_out=0.
//     A new frame with (2,2),(2,2) gives acc_out=8.
//  6. Back-to-back: start in the cycle after handoff -> second frame result correct,
//     overflow from the first frame cleared.

Source files
------------

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Sequential signed multiply-accumulate front end of a neuron.
//               Accepts N_INPUTS (x, w) pairs over a valid/ready stream and
//               produces one saturated signed dot product per frame. A frame
//               is opened by start and closed by the output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac #(
  parameter int N_INPUTS = 2,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [DATA_W-1:0]        x_in,
  input  logic [DATA_W-1:0]        w_in,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     acc_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     overflow
);

  // Counter is sized to hold N_INPUTS itself, so it never wraps in a frame.
  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic [ACC_W-1:0] c_ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [ACC_W-1:0]   r_acc;
  logic               r_acc_valid;
  logic               r_overflow;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]  w_sum;
  logic                     w_sat_hit;
  logic [ACC_W-1:0]         w_acc_next;
  logic                     w_accept;

  // Product, widened sum and clamp; one guard bit is enough because the
  // product magnitude is far below the accumulator range.
  always_comb begin
    w_prod     = $signed(x_in) * $signed(w_in);
    w_sum      = $signed({r_acc[ACC_W-1], r_acc})
               + $signed({{(SUM_W-PROD_W){w_prod[PROD_W-1]}}, w_prod});
    w_sat_hit  = w_sum[SUM_W-1] ^ w_sum[SUM_W-2];
    w_acc_next = w_sum[ACC_W-1:0];
    if (w_sat_hit) begin
      w_acc_next = w_sum[SUM_W-1] ? c_ACC_MIN : c_ACC_MAX;
    end
  end

  assign w_accept = (r_state == ACCUM) && x_valid;

  // Next-state decode; start in DONE (including the handoff cycle) is ignored.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = ACCUM;
      ACCUM:   if (x_valid && (r_count == c_LAST_CNT)) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register and result-valid flag (valid tracks entry into DONE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc_valid <= (w_state_next == DONE);
    end
  end

  // Accumulator, pair counter and sticky overflow; all hold outside ACCUM
  // except the clear on a frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_acc      <= w_acc_next;
      r_count    <= r_count + CNT_W'(1);
      r_overflow <= r_overflow | w_sat_hit;
    end
  end

  assign x_ready   = (r_state == ACCUM);
  assign busy      = (r_state != IDLE);
  assign acc_out   = r_acc;
  assign acc_valid = r_acc_valid;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac
// Description : Directed, table-driven bench for neuron_mac. Instance 0 is
//               built with N_INPUTS=2, instance 1 with N_INPUTS=5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s   [2];
  logic        x_valid_s [2];
  logic        x_ready_s [2];
  logic [7:0]  x_s       [2];
  logic [7:0]  w_s       [2];
  logic [16:0] acc_s     [2];
  logic        acc_valid_s [2];
  logic        out_ready_s [2];
  logic        busy_s    [2];
  logic        ovf_s     [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuron_mac #(.N_INPUTS(2), .DATA_W(8), .ACC_W(17)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .x_valid(x_valid_s[0]),
    .x_ready(x_ready_s[0]), .x_in(x_s[0]), .w_in(w_s[0]), .acc_out(acc_s[0]),
    .acc_valid(acc_valid_s[0]), .out_ready(out_ready_s[0]), .busy(busy_s[0]),
    .overflow(ovf_s[0])
  );

  neuron_mac #(.N_INPUTS(5), .DATA_W(8), .ACC_W(17)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .x_valid(x_valid_s[1]),
    .x_ready(x_ready_s[1]), .x_in(x_s[1]), .w_in(w_s[1]), .acc_out(acc_s[1]),
    .acc_valid(acc_valid_s[1]), .out_ready(out_ready_s[1]), .busy(busy_s[1]),
    .overflow(ovf_s[1])
  );

  typedef struct {
    string name;
    int    sel;
    int    n;
    int    x [5];
    int    w [5];
    int    exp_acc;
    int    exp_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int acc_of(int sel);
    logic signed [16:0] v;
    v = acc_s[sel];
    return int'(v);
  endfunction

  task automatic run_frame(vec_t v);
    int s;
    s = v.sel;
    start_s[s] = 1'b1;
    tick();
    start_s[s] = 1'b0;
    check({v.name, " busy after start"}, int'(busy_s[s]), 1);
    check({v.name, " x_ready in accum"}, int'(x_ready_s[s]), 1);
    for (int i = 0; i < v.n; i++) begin
      x_valid_s[s] = 1'b1;
      x_s[s] = 8'(v.x[i]);
      w_s[s] = 8'(v.w[i]);
      tick();
      if (i < v.n - 1) check({v.name, " acc_valid early"}, int'(acc_valid_s[s]), 0);
    end
    x_valid_s[s] = 1'b0;
    check({v.name, " acc_valid"}, int'(acc_valid_s[s]), 1);
    check({v.name, " x_ready in done"}, int'(x_ready_s[s]), 0);
    check({v.name, " acc_out"}, acc_of(s), v.exp_acc);
    check({v.name, " overflow"}, int'(ovf_s[s]), v.exp_ovf);
    out_ready_s[s] = 1'b1;
    tick();
    out_ready_s[s] = 1'b0;
    check({v.name, " acc_valid after handoff"}, int'(acc_valid_s[s]), 0);
    check({v.name, " busy after handoff"}, int'(busy_s[s]), 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; x_valid_s[k] = 1'b0; x_s[k] = '0; w_s[k] = '0;
      out_ready_s[k] = 1'b0;
    end

    vecs[0] = '{"n2_basic",    0, 2, '{3, -5, 0, 0, 0},       '{4, 6, 0, 0, 0},            -18,    0};
    vecs[1] = '{"n2_maxmag",   0, 2, '{-128, -128, 0, 0, 0},  '{-128, -128, 0, 0, 0},      32768,  0};
    vecs[2] = '{"n2_small",    0, 2, '{2, 2, 0, 0, 0},        '{2, 2, 0, 0, 0},            8,      0};
    vecs[3] = '{"n5_pos_sat",  1, 5, '{-128, -128, -128, -128, -128}, '{-128, -128, -128, -128, -128}, 65535, 1};
    vecs[4] = '{"n5_mixed",    1, 5, '{1, 2, -4, 10, 7},      '{1, 3, 5, -10, 7},          -64,    0};
    vecs[5] = '{"n5_neg_sat",  1, 5, '{-128, -128, -128, -128, -128}, '{127, 127, 127, 127, 127}, -65536, 1};
    vecs[6] = '{"n5_sat_recover", 1, 5, '{-128, -128, -128, -128, -128}, '{-128, -128, -128, -128, 127}, 49279, 1};

    // Reset, then idle: every output low.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    for (int k = 0; k < 2; k++) begin
      check("reset acc_out",   acc_of(k), 0);
      check("reset acc_valid", int'(acc_valid_s[k]), 0);
      check("reset x_ready",   int'(x_ready_s[k]), 0);
      check("reset busy",      int'(busy_s[k]), 0);
      check("reset overflow",  int'(ovf_s[k]), 0);
    end

    // Table: frames run back-to-back per instance, so each start lands in the
    // cycle after the previous handoff and overflow must clear (n5_pos_sat -> n5_mixed).
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Stalled input stream, held output, ignored start pulses (N=2).
    start_s[0] = 1'b1; tick(); start_s[0] = 1'b0;
    x_valid_s[0] = 1'b1; x_s[0] = 8'd1; w_s[0] = 8'd1; tick();
    x_valid_s[0] = 1'b0; start_s[0] = 1'b1; tick();
    start_s[0] = 1'b0; tick();
    check("stall still accum", int'(x_ready_s[0]), 1);
    check("stall no valid",    int'(acc_valid_s[0]), 0);
    x_valid_s[0] = 1'b1; x_s[0] = 8'd2; w_s[0] = 8'd2; tick();
    x_s[0] = 8'd9; w_s[0] = 8'd9; start_s[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("hold acc_valid", int'(acc_valid_s[0]), 1);
      check("hold acc_out",   acc_of(0), 5);
      tick();
    end
    x_valid_s[0] = 1'b0;
    out_ready_s[0] = 1'b1; tick();
    out_ready_s[0] = 1'b0;
    check("handoff valid low", int'(acc_valid_s[0]), 0);
    start_s[0] = 1'b0; tick();
    check("start at handoff ignored", int'(busy_s[0]), 0);
    check("acc_out held after handoff", acc_of(0), 5);
    x_valid_s[0] = 1'b1; tick(); x_valid_s[0] = 1'b0;
    check("x_valid in idle ignored", int'(x_ready_s[0]), 0);
    check("acc_out still held", acc_of(0), 5);

    // Reset in the middle of a frame discards it.
    start_s[0] = 1'b1; tick(); start_s[0] = 1'b0;
    x_valid_s[0] = 1'b1; x_s[0] = 8'd3; w_s[0] = 8'd3; tick();
    x_valid_s[0] = 1'b0;
    check("mid-frame acc", acc_of(0), 9);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mid reset busy",  int'(busy_s[0]), 0);
    check("mid reset acc",   acc_of(0), 0);
    check("mid reset valid", int'(acc_valid_s[0]), 0);
    tick();
    check("no result after reset", int'(acc_valid_s[0]), 0);
    run_frame(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
